// File: rtl/cvae_pkg.sv
// Shared types and sizing constants for the CVAE host sequencer.
// Imported by the sequencer top and its skid FIFO.
package cvae_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 16;
    localparam int INIT_WORDS  = 23;
    localparam int STATE_WORDS = 13;
    localparam int STATE_BASE  = 13;
    localparam int MAX_SEQ     = 60;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_START,
        ST_BURST,
        ST_WAIT_FIN,
        ST_READ,
        ST_DONE
    } state_e;

endpackage

// File: rtl/cvae_skid_fifo.sv
// Two-entry FIFO carrying a data word plus a last flag, with valid/ready on both sides.
// Outputs come straight from storage, so out_data_o is stable while stalled.
module cvae_skid_fifo
    import cvae_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    output logic [1:0]       count_o
);

    logic [WIDTH:0] mem_q [2];
    logic           wr_ptr_q;
    logic           rd_ptr_q;
    logic [1:0]     count_q;
    logic           push;
    logic           pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    assign out_last_o  = out_valid_o && mem_q[rd_ptr_q][WIDTH];
    assign count_o     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {in_last_i, in_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cvae_host_seq.sv
// Host-side sequencer for the CVAE accelerator: collects the init burst, replays it,
// waits for completion and streams the resulting state records out of state SRAM.
module cvae_host_seq
    import cvae_pkg::*;
#(
    parameter int DATA_WIDTH  = cvae_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = cvae_pkg::ADDR_WIDTH,
    parameter int INIT_WORDS  = cvae_pkg::INIT_WORDS,
    parameter int STATE_WORDS = cvae_pkg::STATE_WORDS,
    parameter int MAX_SEQ     = cvae_pkg::MAX_SEQ,
    parameter int FIN_TIMEOUT = 220000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_go,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  start,
    output logic [DATA_WIDTH-1:0] init_data,
    input  logic                  finish,
    input  logic [5:0]            seq_lens,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done,
    output logic [1:0]            err,
    output logic [5:0]            seq_len_q
);

    localparam int CW = $clog2(INIT_WORDS);
    localparam int TW = $clog2(FIN_TIMEOUT + 1);
    localparam int NW = $clog2(MAX_SEQ * STATE_WORDS + 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NW-1:0]         total_q, total_d;
    logic [NW-1:0]         issued_q, issued_d;
    logic [1:0]            err_q, err_d;
    logic [5:0]            seq_len_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [DATA_WIDTH-1:0] ibuf_q [INIT_WORDS];

    logic                  fifo_in_ready;
    logic [1:0]            fifo_count;
    logic                  pop;
    logic                  room;
    logic                  rd_last;
    logic [5:0]            n_clamped;

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_FILL);
    assign start     = (state_q == ST_START);
    assign done      = (state_q == ST_DONE);
    assign init_data = (state_q == ST_BURST) ? ibuf_q[cnt_q] : '0;
    assign rd_addr   = addr_q;
    assign err       = err_q;

    assign n_clamped = (seq_lens > 6'(MAX_SEQ)) ? 6'(MAX_SEQ) : seq_lens;

    // A read may only launch if the FIFO will still have a free slot when its data lands,
    // counting the word already in flight and any word leaving this cycle.
    assign pop     = out_valid && out_ready;
    assign room    = (({1'b0, fifo_count} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;
    assign rd_en   = (state_q == ST_READ) && (issued_q != total_q) && room && fifo_in_ready;
    assign rd_last = (issued_q == total_q - NW'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        addr_d    = addr_q;
        total_d   = total_q;
        issued_d  = issued_q;
        err_d     = err_q;
        seq_len_d = seq_len_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_go) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    err_d   = 2'b00;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    if (cnt_q == CW'(INIT_WORDS - 1)) begin
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_START: begin
                cnt_d   = '0;
                timer_d = timer_q + TW'(1);
                state_d = ST_BURST;
            end
            ST_BURST: begin
                timer_d = timer_q + TW'(1);
                if (cnt_q == CW'(INIT_WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_FIN: begin
                if (finish) begin
                    seq_len_d = n_clamped;
                    err_d[1]  = (seq_lens > 6'(MAX_SEQ));
                    total_d   = NW'(n_clamped) * NW'(STATE_WORDS);
                    issued_d  = '0;
                    addr_d    = ADDR_WIDTH'(STATE_BASE);
                    state_d   = (n_clamped == 6'd0) ? ST_DONE : ST_READ;
                end else if (timer_q == TW'(FIN_TIMEOUT - 1)) begin
                    err_d[0] = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_READ: begin
                if (rd_en) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + NW'(1);
                end
                if (pop && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            timer_q         <= '0;
            addr_q          <= '0;
            total_q         <= '0;
            issued_q        <= '0;
            err_q           <= 2'b00;
            seq_len_q       <= 6'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            timer_q         <= timer_d;
            addr_q          <= addr_d;
            total_q         <= total_d;
            issued_q        <= issued_d;
            err_q           <= err_d;
            seq_len_q       <= seq_len_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && rd_last;
        end
    end

    // The init buffer is only ever read in BURST after a full FILL, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_FILL && in_valid) begin
            ibuf_q[cnt_q] <= in_data;
        end
    end

    cvae_skid_fifo #(
        .WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (inflight_q),
        .in_ready_o (fifo_in_ready),
        .in_data_i  (rd_data),
        .in_last_i  (inflight_last_q),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .count_o    (fifo_count)
    );

endmodule
